// File: rtl/char_lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : char_lcd_pkg
//  Purpose  : Shared constants for the HD44780 character LCD controller:
//             command bytes, sequence step indices, counter limits, the
//             default tick divider and a character-index helper.
//  Revision : 1.0 - initial release
// ============================================================================
package char_lcd_pkg;

    // System clocks per LCD tick (50 MHz -> 1 kHz)
    localparam int unsigned c_clk_div_default = 50000;

    // HD44780 command bytes
    localparam logic [7:0] c_cmd_func_set    = 8'h38;
    localparam logic [7:0] c_cmd_display_on  = 8'h0C;
    localparam logic [7:0] c_cmd_entry_mode  = 8'h06;
    localparam logic [7:0] c_cmd_clear       = 8'h01;
    localparam logic [7:0] c_cmd_line1_addr  = 8'h80;
    localparam logic [7:0] c_cmd_line2_addr  = 8'hC0;

    // Sequence step indices
    localparam logic [6:0] c_step_line1_cmd   = 7'd5;
    localparam logic [6:0] c_step_line1_first = 7'd6;
    localparam logic [6:0] c_step_line2_cmd   = 7'd22;
    localparam logic [6:0] c_step_line2_first = 7'd23;
    localparam logic [6:0] c_step_last        = 7'd38;

    // Sequence counter limits
    localparam logic [8:0] c_last_cnt    = 9'd155;  // step 38, phase 3
    localparam logic [8:0] c_refresh_cnt = 9'd20;   // step 5, phase 0

    // Maps a character step to its byte index in char_data (0-31).
    // Non-character steps return 0; the caller only uses the result for
    // character steps.
    function automatic logic [4:0] char_index(input logic [6:0] step);
        logic [4:0] v_idx;
        v_idx = 5'd0;
        if ((step >= c_step_line1_first) && (step < c_step_line2_cmd)) begin
            v_idx = 5'(step - c_step_line1_first);
        end else if ((step >= c_step_line2_first) && (step <= c_step_last)) begin
            v_idx = 5'(step - c_step_line2_first + 7'd16);
        end
        return v_idx;
    endfunction

endpackage : char_lcd_pkg
`default_nettype wire

// File: rtl/char_lcd_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : char_lcd_clk_div
//  Purpose  : LCD tick generator. Emits a one-clk tick pulse every CLK_DIV
//             system clocks using a 16-bit divider.
//  Ports    : clk   - system clock (rising edge)
//             reset - synchronous active-high reset
//             tick  - one-clk pulse at the divider terminal count
//  Revision : 1.0 - initial release
// ============================================================================
module char_lcd_clk_div
    import char_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = c_clk_div_default
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] c_term = 16'(CLK_DIV - 1);

    logic [15:0] r_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= 16'd0;
        end else if (r_div == c_term) begin
            r_div <= 16'd0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Divider starts at 0 after reset, so the first tick lands CLK_DIV clocks
    // after release.
    assign tick = (r_div == c_term);

endmodule : char_lcd_clk_div
`default_nettype wire

// File: rtl/char_lcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : char_lcd_controller
//  Purpose  : Writes 32 ASCII characters to a 2x16 HD44780 LCD. A 9-bit
//             sequence counter (step = cnt[8:2], phase = cnt[1:0]) walks the
//             init commands, line-1 address, 16 chars, line-2 address and
//             16 chars. Enable is high in phases 1-2 for setup/hold margin.
//  Ports    : clk       - system clock (rising edge)
//             reset     - synchronous active-high reset
//             char_data - 32 bytes, byte i at [8i+7:8i]; 0-15 line 1,
//                         16-31 line 2
//             lcd_e     - enable strobe
//             lcd_rs    - register select (0 command, 1 data)
//             lcd_rw    - read/write, always 0
//             lcd_db    - data bus
//  Config   : CHAR_LCD_REFRESH_EN - when defined, the sequence reloads to
//             step 5 after the last character and rewrites both lines
//             forever; otherwise it halts at the last count until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module char_lcd_controller
    import char_lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = c_clk_div_default
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] char_data,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_db
);

    logic       w_tick;
    logic [8:0] r_lcd_cnt;
    logic [8:0] w_cnt_next;
    logic [6:0] w_step;
    logic [1:0] w_phase;
    logic       w_capture;
    logic [4:0] w_char_idx;
    logic [7:0] w_char_sel;
    logic [7:0] r_char;
    logic       r_lcd_e;
    logic       r_lcd_rs;
    logic [7:0] r_lcd_db;

    char_lcd_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_step  = r_lcd_cnt[8:2];
    assign w_phase = r_lcd_cnt[1:0];

    always_comb begin
        w_cnt_next = r_lcd_cnt;
        if (w_tick) begin
            if (r_lcd_cnt == c_last_cnt) begin
`ifdef CHAR_LCD_REFRESH_EN
                w_cnt_next = c_refresh_cnt;
`else
                w_cnt_next = c_last_cnt;
`endif
            end else begin
                w_cnt_next = r_lcd_cnt + 9'd1;
            end
        end
    end

    // The character byte is latched as the counter enters phase 0 of the
    // next step, so char_data changes later in the step cannot disturb the
    // bus. The hold state at the last count never re-enters phase 0.
    assign w_capture  = w_tick && (w_cnt_next != r_lcd_cnt) && (w_cnt_next[1:0] == 2'd0);
    assign w_char_idx = char_index(w_cnt_next[8:2]);
    assign w_char_sel = char_data[{w_char_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lcd_cnt <= 9'd0;
            r_char    <= 8'h00;
            r_lcd_e   <= 1'b0;
            r_lcd_rs  <= 1'b0;
            r_lcd_db  <= 8'h00;
        end else begin
            r_lcd_cnt <= w_cnt_next;
            if (w_capture) begin
                r_char <= w_char_sel;
            end

            // Outputs decode the current count, one clk behind it.
            r_lcd_e <= (w_phase == 2'd1) || (w_phase == 2'd2);

            case (w_step)
                7'd0, 7'd1: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_func_set;
                end
                7'd2: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_display_on;
                end
                7'd3: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_entry_mode;
                end
                7'd4: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_clear;
                end
                c_step_line1_cmd: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_line1_addr;
                end
                c_step_line2_cmd: begin
                    r_lcd_rs <= 1'b0;
                    r_lcd_db <= c_cmd_line2_addr;
                end
                default: begin
                    r_lcd_rs <= 1'b1;
                    r_lcd_db <= r_char;
                end
            endcase
        end
    end

    assign lcd_e  = r_lcd_e;
    assign lcd_rs = r_lcd_rs;
    assign lcd_rw = 1'b0;
    assign lcd_db = r_lcd_db;

endmodule : char_lcd_controller
`default_nettype wire

// File: tb/tb_char_lcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_lcd_controller
//  Purpose  : Directed self-checking bench for char_lcd_controller with
//             CLK_DIV=4. Each count lasts 4 clks and each step 16 clks; after
//             release the outputs show count n from the 4n-th edge on.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_char_lcd_controller;

    logic         clk;
    logic         reset;
    logic [255:0] char_data;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_db;

    int n_cmp;
    int n_fail;
    int edge_idx;

    char_lcd_controller #(
        .CLK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .char_data (char_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db    (lcd_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic clk1();
        @(posedge clk);
        #1;
        edge_idx++;
    endtask

    task automatic run_to(input int target);
        while (edge_idx < target) clk1();
    endtask

    initial begin
        logic [7:0] step_cmd [2:5];
        int         hi;
        int         lo;
        int         db_chg;
        int         clr_seen;
        logic       prev_e;
        logic [7:0] prev_db;

        n_cmp     = 0;
        n_fail    = 0;
        edge_idx  = 0;
        step_cmd[2] = 8'h0C;
        step_cmd[3] = 8'h06;
        step_cmd[4] = 8'h01;
        step_cmd[5] = 8'h80;

        // byte i = 0x41+i, except byte0=0x4D and byte16=0x4B; byte31 = 0x60
        for (int i = 0; i < 32; i++) char_data[8*i +: 8] = 8'(8'h41 + i);
        char_data[7:0]     = 8'h4D;
        char_data[135:128] = 8'h4B;

        // Reset for 3 clocks
        reset = 1'b1;
        clk1();
        clk1();
        clk1();
        check("rst_e",  {31'd0, lcd_e},  32'h0);
        check("rst_rs", {31'd0, lcd_rs}, 32'h0);
        check("rst_rw", {31'd0, lcd_rw}, 32'h0);
        check("rst_db", {24'd0, lcd_db}, 32'h0);

        // Release: first edge after release is index 0 (count 0)
        reset    = 1'b0;
        edge_idx = -1;
        clk1();
        check("rel_db", {24'd0, lcd_db}, 32'h38);
        check("rel_rs", {31'd0, lcd_rs}, 32'h0);
        check("rel_rw", {31'd0, lcd_rw}, 32'h0);
        check("rel_e",  {31'd0, lcd_e},  32'h0);
        run_to(3);
        check("pre_tick_e", {31'd0, lcd_e}, 32'h0);
        run_to(4);
        check("s0p1_e",  {31'd0, lcd_e},  32'h1);
        check("s0p1_db", {24'd0, lcd_db}, 32'h38);

        // Steps 2-5: enable duty and bus stability while enabled
        for (int s = 2; s <= 5; s++) begin
            hi = 0;
            lo = 0;
            db_chg = 0;
            prev_e  = 1'b0;
            prev_db = 8'h00;
            for (int j = 0; j < 16; j++) begin
                run_to(16 * s + j);
                if (j == 0) begin
                    check($sformatf("step%0d_db", s), {24'd0, lcd_db}, {24'd0, step_cmd[s]});
                    check($sformatf("step%0d_rs", s), {31'd0, lcd_rs}, 32'h0);
                end
                if (lcd_e === 1'b1) begin
                    hi++;
                    if (prev_e === 1'b1 && lcd_db !== prev_db) db_chg++;
                end else begin
                    lo++;
                end
                prev_e  = lcd_e;
                prev_db = lcd_db;
            end
            check($sformatf("step%0d_e_hi", s), hi, 8);
            check($sformatf("step%0d_e_lo", s), lo, 8);
            check($sformatf("step%0d_db_chg", s), db_chg, 0);
        end

        // Step 6 (count 24): first character
        run_to(96);
        check("s6_db", {24'd0, lcd_db}, 32'h4D);
        check("s6_rs", {31'd0, lcd_rs}, 32'h1);
        run_to(100);
        check("s6p1_e", {31'd0, lcd_e}, 32'h1);
        char_data[7:0] = 8'h79;
        run_to(104);
        check("s6p2_db_held", {24'd0, lcd_db}, 32'h4D);
        run_to(108);
        check("s6p3_db_held", {24'd0, lcd_db}, 32'h4D);
        run_to(112);
        check("s7_db", {24'd0, lcd_db}, 32'h42);

        // Line 2
        run_to(352);
        check("s22_db", {24'd0, lcd_db}, 32'hC0);
        check("s22_rs", {31'd0, lcd_rs}, 32'h0);
        run_to(368);
        check("s23_db", {24'd0, lcd_db}, 32'h4B);
        check("s23_rs", {31'd0, lcd_rs}, 32'h1);
        run_to(608);
        check("s38_db", {24'd0, lcd_db}, 32'h60);
        run_to(620);
        check("c155_e",  {31'd0, lcd_e},  32'h0);
        check("c155_db", {24'd0, lcd_db}, 32'h60);

        // Past the last count
        run_to(624);
`ifdef CHAR_LCD_REFRESH_EN
        check("reload_db", {24'd0, lcd_db}, 32'h80);
        check("reload_rs", {31'd0, lcd_rs}, 32'h0);
        check("reload_e",  {31'd0, lcd_e},  32'h0);
        clr_seen = 0;
        for (int k = 625; k < 640; k++) begin
            run_to(k);
            if (lcd_db === 8'h01) clr_seen++;
        end
        check("no_clear", clr_seen, 0);
        run_to(640);
        check("refresh_s6_db", {24'd0, lcd_db}, 32'h79);
        check("refresh_s6_rs", {31'd0, lcd_rs}, 32'h1);
`else
        check("hold_db", {24'd0, lcd_db}, 32'h60);
        check("hold_rs", {31'd0, lcd_rs}, 32'h1);
        check("hold_e",  {31'd0, lcd_e},  32'h0);
        hi = 0;
        db_chg = 0;
        for (int k = 625; k < 680; k++) begin
            run_to(k);
            if (lcd_e !== 1'b0) hi++;
            if (lcd_db !== 8'h60) db_chg++;
        end
        check("hold_e_hi", hi, 0);
        check("hold_db_chg", db_chg, 0);
        clr_seen = 0;
        check("hold_clr", clr_seen, 0 * hi);
`endif

        // Reset pulse at step 10, phase 1 (count 41) of a fresh run
        reset = 1'b1;
        clk1();
        clk1();
        reset    = 1'b0;
        edge_idx = -1;
        clk1();
        run_to(164);
        check("s10p1_e",  {31'd0, lcd_e},  32'h1);
        check("s10p1_db", {24'd0, lcd_db}, 32'h45);
        reset = 1'b1;
        clk1();
        check("abort_e",  {31'd0, lcd_e},  32'h0);
        check("abort_db", {24'd0, lcd_db}, 32'h0);
        check("abort_rs", {31'd0, lcd_rs}, 32'h0);
        reset    = 1'b0;
        edge_idx = -1;
        clk1();
        check("restart_db", {24'd0, lcd_db}, 32'h38);
        check("restart_e",  {31'd0, lcd_e},  32'h0);
        run_to(4);
        check("restart_s0p1_e",  {31'd0, lcd_e},  32'h1);
        check("restart_s0p1_db", {24'd0, lcd_db}, 32'h38);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_char_lcd_controller
`default_nettype wire
